// File: rtl/ahb_split_slave_if.sv
// ahb_split_slave_if: AHB address/data signals seen by the split-capable slave,
// plus the arbiter outputs (HMASTER/HMASTLOCK) and the HSPLITx release vector.
interface ahb_split_slave_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic        HREADY;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [15:0] HSPLITx;

  modport master (
    output HSEL, HTRANS, HWRITE, HADDR, HREADY, HMASTER, HMASTLOCK,
    input  HREADYOUT, HRESP, HRDATA, HSPLITx
  );

  modport slave (
    input  HSEL, HTRANS, HWRITE, HADDR, HREADY, HMASTER, HMASTLOCK,
    output HREADYOUT, HRESP, HRDATA, HSPLITx
  );
endinterface

// File: rtl/ahb_split_slave.sv
// ahb_split_slave: slow AHB target. Each non-locked transfer in idle starts a
// LATENCY-cycle job and is answered SPLIT; the owner is released through
// HSPLITx when the job finishes and completes on its retry. Masters split
// while the job is busy are remembered and released once the job retires.
// Locked transfers are never split: in idle they are served with wait states,
// while a job is in flight they get ERROR.
module ahb_split_slave #(
  parameter int unsigned LATENCY = 8
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_split_slave_if.slave bus
);

  localparam logic [7:0] LAT_M1     = 8'(LATENCY - 1);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_RUN  = 2'd1,
    J_DONE = 2'd2
  } job_state_e;

  typedef enum logic [1:0] {
    R_OK     = 2'd0,
    R_WAIT   = 2'd1,
    R_FIRST  = 2'd2,
    R_SECOND = 2'd3
  } resp_state_e;

  // What the job side decided about the transfer sampled this cycle.
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_SPLIT = 3'd1,
    ACT_ERROR = 3'd2,
    ACT_DATA  = 3'd3,
    ACT_LOCK  = 3'd4
  } act_e;

  job_state_e  job_state_q, job_state_d;
  logic [3:0]  owner_q, owner_d;
  logic [31:0] job_addr_q, job_addr_d;
  logic [7:0]  job_cnt_q, job_cnt_d;
  logic [15:0] pending_q, pending_d;

  resp_state_e resp_state_q, resp_state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] lock_addr_q, lock_addr_d;

  logic        hreadyout_q, hreadyout_d;
  logic [1:0]  hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [15:0] hsplit_q, hsplit_d;

  logic        valid_s;
  logic        is_owner_s;
  act_e        act_s;
  logic        unused_ok;

  // A transfer is only taken while this slave itself is not stalling the bus.
  assign valid_s    = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hreadyout_q;
  assign is_owner_s = (bus.HMASTER == owner_q);
  // Write direction and the SEQ/NONSEQ distinction do not affect behaviour.
  assign unused_ok  = ^{bus.HWRITE, bus.HTRANS[0]};

  // Job FSM: capture, countdown, owner release, retirement and pending bookkeeping.
  always_comb begin
    job_state_d = job_state_q;
    owner_d     = owner_q;
    job_addr_d  = job_addr_q;
    job_cnt_d   = job_cnt_q;
    pending_d   = pending_q;
    hsplit_d    = 16'h0000;
    act_s       = ACT_NONE;
    case (job_state_q)
      J_IDLE: begin
        if (valid_s) begin
          if (bus.HMASTLOCK) begin
            act_s = ACT_LOCK;
          end else begin
            act_s       = ACT_SPLIT;
            owner_d     = bus.HMASTER;
            job_addr_d  = bus.HADDR;
            job_cnt_d   = LAT_M1;
            job_state_d = J_RUN;
          end
        end else begin
          act_s = ACT_NONE;
        end
      end
      J_RUN: begin
        if (job_cnt_q == 8'd0) begin
          job_state_d       = J_DONE;
          hsplit_d[owner_q] = 1'b1;
        end else begin
          job_cnt_d = job_cnt_q - 8'd1;
        end
        if (valid_s) begin
          if (bus.HMASTLOCK) begin
            act_s = ACT_ERROR;
          end else begin
            act_s = ACT_SPLIT;
            // The owner is already tracked; only bystanders need a release later.
            if (!is_owner_s) begin
              pending_d[bus.HMASTER] = 1'b1;
            end else begin
              pending_d = pending_d;
            end
          end
        end else begin
          act_s = ACT_NONE;
        end
      end
      J_DONE: begin
        if (valid_s) begin
          if (bus.HMASTLOCK) begin
            act_s = ACT_ERROR;
          end else if (is_owner_s) begin
            // Retirement: release everyone split meanwhile in the next cycle.
            act_s       = ACT_DATA;
            job_state_d = J_IDLE;
            hsplit_d    = pending_q;
            pending_d   = 16'h0000;
          end else begin
            act_s                  = ACT_SPLIT;
            pending_d[bus.HMASTER] = 1'b1;
          end
        end else begin
          act_s = ACT_NONE;
        end
      end
      default: begin
        job_state_d = J_IDLE;
      end
    endcase
  end

  // Response FSM: two-cycle SPLIT/ERROR, locked wait states and read data.
  always_comb begin
    resp_state_d = resp_state_q;
    wait_cnt_d   = wait_cnt_q;
    lock_addr_d  = lock_addr_q;
    hreadyout_d  = 1'b1;
    hresp_d      = RESP_OKAY;
    hrdata_d     = 32'h0000_0000;
    case (resp_state_q)
      R_WAIT: begin
        if (wait_cnt_q == 8'd0) begin
          resp_state_d = R_OK;
          hrdata_d     = lock_addr_q;
        end else begin
          wait_cnt_d  = wait_cnt_q - 8'd1;
          hreadyout_d = 1'b0;
        end
      end
      R_FIRST: begin
        resp_state_d = R_SECOND;
        hresp_d      = hresp_q;
      end
      R_OK, R_SECOND: begin
        resp_state_d = R_OK;
        case (act_s)
          ACT_SPLIT: begin
            resp_state_d = R_FIRST;
            hreadyout_d  = 1'b0;
            hresp_d      = RESP_SPLIT;
          end
          ACT_ERROR: begin
            resp_state_d = R_FIRST;
            hreadyout_d  = 1'b0;
            hresp_d      = RESP_ERROR;
          end
          ACT_DATA: begin
            hrdata_d = job_addr_q;
          end
          ACT_LOCK: begin
            resp_state_d = R_WAIT;
            wait_cnt_d   = LAT_M1;
            lock_addr_d  = bus.HADDR;
            hreadyout_d  = 1'b0;
          end
          default: begin
            resp_state_d = R_OK;
          end
        endcase
      end
      default: begin
        resp_state_d = R_OK;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      job_state_q  <= J_IDLE;
      owner_q      <= 4'h0;
      job_addr_q   <= 32'h0000_0000;
      job_cnt_q    <= 8'd0;
      pending_q    <= 16'h0000;
      resp_state_q <= R_OK;
      wait_cnt_q   <= 8'd0;
      lock_addr_q  <= 32'h0000_0000;
      hreadyout_q  <= 1'b1;
      hresp_q      <= RESP_OKAY;
      hrdata_q     <= 32'h0000_0000;
      hsplit_q     <= 16'h0000;
    end else begin
      job_state_q  <= job_state_d;
      owner_q      <= owner_d;
      job_addr_q   <= job_addr_d;
      job_cnt_q    <= job_cnt_d;
      pending_q    <= pending_d;
      resp_state_q <= resp_state_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_addr_q  <= lock_addr_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      hrdata_q     <= hrdata_d;
      hsplit_q     <= hsplit_d;
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.HSPLITx   = hsplit_q;

endmodule

// File: tb/tb_ahb_split_slave.sv
// tb_ahb_split_slave: directed scenarios for the split slave. Stimulus pushes
// the expected data-phase response and the expected HSPLITx pulses into
// queues; an independent monitor pops and compares them as the bus shows them.
module tb_ahb_split_slave;

  localparam int LAT = 8;
  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam logic [1:0] SPLIT = 2'b11;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          waits;
    string       name;
  } rsp_t;

  typedef struct {
    logic [15:0] mask;
    int          cyc;
    string       name;
  } spl_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  rsp_t rsp_q[$];
  spl_t spl_q[$];
  rsp_t mon_r;
  spl_t mon_s;
  int   waits_seen = 0;
  bit   wait_bad = 1'b0;

  always #5 clk = ~clk;

  // Edge counter used to time HSPLITx pulses.
  always @(posedge clk) cyc <= cyc + 1;

  ahb_split_slave_if bus();
  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign bus.HREADY = bus.HREADYOUT;

  ahb_split_slave #(.LATENCY(LAT)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_idle();
    bus.HSEL      = 1'b0;
    bus.HTRANS    = 2'b00;
    bus.HWRITE    = 1'b0;
    bus.HADDR     = 32'h0;
    bus.HMASTER   = 4'h0;
    bus.HMASTLOCK = 1'b0;
  endtask

  // Present a NONSEQ read until the slave takes it; queue its expected response.
  // cap is the counter value at the sampling edge (before that edge's increment).
  task automatic xfer(input string name, input logic [3:0] m, input logic [31:0] a,
                      input bit lk, input logic [1:0] er, input logic [31:0] ed,
                      input int ew, output int cap);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    cap = 0;
    bus.HSEL      = 1'b1;
    bus.HTRANS    = 2'b10;
    bus.HWRITE    = 1'b0;
    bus.HADDR     = a;
    bus.HMASTER   = m;
    bus.HMASTLOCK = lk;
    while (!got && n < 50) begin
      @(posedge clk);
      if (bus.HREADYOUT === 1'b1) begin
        got = 1'b1;
        cap = cyc;
        rsp_q.push_back('{er, ed, ew, name});
      end
      n++;
    end
    if (!got) begin
      chk({name, ".accepted"}, 64'd0, 64'd1);
      cap = cyc;
    end
    #1;
    drive_idle();
  endtask

  task automatic exp_split(input string name, input logic [15:0] mask, input int at);
    spl_q.push_back('{mask, at, name});
  endtask

  // Wait until every expected HSPLITx pulse has been seen, bounded.
  task automatic wait_split(input string name, input int budget);
    int n;
    n = 0;
    while (spl_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (spl_q.size() != 0) begin
      chk({name, ".hsplit_seen"}, 64'(spl_q.size()), 64'd0);
      spl_q.delete();
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".hreadyout"}, 64'(bus.HREADYOUT), 64'd1);
    chk({name, ".hresp"},     64'(bus.HRESP),     64'd0);
    chk({name, ".hrdata"},    64'(bus.HRDATA),    64'd0);
    chk({name, ".hsplitx"},   64'(bus.HSPLITx),   64'd0);
  endtask

  // Monitor: pops expected responses and HSPLITx pulses as the bus shows them.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_q.size() != 0) begin
          if (bus.HREADYOUT !== 1'b1) begin
            waits_seen++;
            if (bus.HRESP !== rsp_q[0].resp || bus.HRDATA !== 32'h0) wait_bad = 1'b1;
          end else begin
            mon_r = rsp_q.pop_front();
            chk({mon_r.name, ".hresp"},      64'(bus.HRESP),  64'(mon_r.resp));
            chk({mon_r.name, ".hrdata"},     64'(bus.HRDATA), 64'(mon_r.data));
            chk({mon_r.name, ".waits"},      64'(waits_seen), 64'(mon_r.waits));
            chk({mon_r.name, ".wait_phase"}, 64'(wait_bad),   64'd0);
            waits_seen = 0;
            wait_bad   = 1'b0;
          end
        end else begin
          chk("idle_outputs", 64'({bus.HREADYOUT, bus.HRESP, bus.HRDATA}),
              64'({1'b1, 2'b00, 32'h0}));
        end
        if (bus.HSPLITx !== 16'h0000) begin
          if (spl_q.size() == 0) begin
            chk("unexpected_hsplitx", 64'(bus.HSPLITx), 64'd0);
          end else begin
            mon_s = spl_q.pop_front();
            chk({mon_s.name, ".mask"},  64'(bus.HSPLITx), 64'(mon_s.mask));
            chk({mon_s.name, ".cycle"}, 64'(cyc),         64'(mon_s.cyc));
          end
        end
      end
    end
  end

  // Hard stop in case something unforeseen stalls the scenario sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cap;
    int cap_r;
    int cap4;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;

    // T1: single job for master 3; release LAT cycles after capture, then retry.
    xfer("t1_m3", 4'd3, 32'h0000_1000, 1'b0, SPLIT, 32'h0, 1, cap);
    exp_split("t1_owner_release", 16'h0008, cap + LAT + 1);
    wait_split("t1", 40);
    xfer("t1_retry", 4'd3, 32'h0000_1000, 1'b0, OKAY, 32'h0000_1000, 0, cap);
    idle_cycles(3);

    // T2: masters 5 and 9 split during master 3's job; both released after retirement.
    xfer("t2_m3", 4'd3, 32'h0000_2000, 1'b0, SPLIT, 32'h0, 1, cap);
    exp_split("t2_owner_release", 16'h0008, cap + LAT + 1);
    xfer("t2_m5", 4'd5, 32'h0000_2100, 1'b0, SPLIT, 32'h0, 1, cap);
    xfer("t2_m9", 4'd9, 32'h0000_2200, 1'b0, SPLIT, 32'h0, 1, cap);
    wait_split("t2", 40);
    xfer("t2_retry", 4'd3, 32'h0000_2ABC, 1'b0, OKAY, 32'h0000_2000, 0, cap_r);
    exp_split("t2_pending_release", 16'h0220, cap_r + 1);
    wait_split("t2_pend", 10);
    idle_cycles(4);

    // T3: locked transfer in idle is served with LAT wait states, no job.
    xfer("t3_lock_m2", 4'd2, 32'h0000_0040, 1'b1, OKAY, 32'h0000_0040, LAT, cap);
    idle_cycles(LAT + 4);

    // T4: locked transfer during a job gets ERROR; job still completes.
    xfer("t4_m3", 4'd3, 32'h0000_3000, 1'b0, SPLIT, 32'h0, 1, cap);
    exp_split("t4_owner_release", 16'h0008, cap + LAT + 1);
    xfer("t4_lock_m7", 4'd7, 32'h0000_3300, 1'b1, ERROR, 32'h0, 1, cap);
    wait_split("t4", 40);
    xfer("t4_retry", 4'd3, 32'h0000_3000, 1'b0, OKAY, 32'h0000_3000, 0, cap);
    idle_cycles(4);

    // T5: master 4 arrives in the release cycle of pending mask 0x0020.
    xfer("t5_m3", 4'd3, 32'h0000_5000, 1'b0, SPLIT, 32'h0, 1, cap);
    exp_split("t5_owner_release", 16'h0008, cap + LAT + 1);
    xfer("t5_m5", 4'd5, 32'h0000_5500, 1'b0, SPLIT, 32'h0, 1, cap);
    wait_split("t5", 40);
    xfer("t5_retry", 4'd3, 32'h0000_5000, 1'b0, OKAY, 32'h0000_5000, 0, cap_r);
    exp_split("t5_pending_release", 16'h0020, cap_r + 1);
    xfer("t5_m4", 4'd4, 32'h0000_4400, 1'b0, SPLIT, 32'h0, 1, cap4);
    chk("t5_m4_in_release_cycle", 64'(cap4), 64'(cap_r + 1));
    exp_split("t5_m4_release", 16'h0010, cap4 + LAT + 1);
    wait_split("t5_m4", 40);
    xfer("t5_m4_retry", 4'd4, 32'h0000_9999, 1'b0, OKAY, 32'h0000_4400, 0, cap);
    idle_cycles(4);

    // T6: reset while the job counter reads 3; the job is dropped silently.
    xfer("t6_m1", 4'd1, 32'h0000_6000, 1'b0, SPLIT, 32'h0, 1, cap);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("t6_reset");
    idle_cycles(LAT + 6);
    xfer("t6_m1_fresh", 4'd1, 32'h0000_6600, 1'b0, SPLIT, 32'h0, 1, cap);
    exp_split("t6_owner_release", 16'h0002, cap + LAT + 1);
    wait_split("t6", 40);
    xfer("t6_retry", 4'd1, 32'h0000_6600, 1'b0, OKAY, 32'h0000_6600, 0, cap);
    idle_cycles(6);

    chk("end.responses_outstanding", 64'(rsp_q.size()), 64'd0);
    chk("end.hsplit_outstanding",    64'(spl_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_split_slave.md
Name: ahb_split_slave

Overview:
- AHB slave with split-transaction support; produces the HSPLIT vector the 16-master AHB arbiter consumes, and reads that arbiter's HMASTER/HMASTLOCK outputs.
- Models a slow target: each non-locked transfer starts a LATENCY-cycle job and is answered SPLIT; the owner is released via HSPLITx and completes on retry.
- Fills the upstream HSPLIT slot of the arbiter's bench and replaces the tied-off HSPLIT in arbiter verification.

Parameters:
- LATENCY, 8, job duration in cycles; legal range 2..255.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  reset, synchronous, active-low
- HSEL  input  1  slave select
- HTRANS  input  2  transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- HWRITE  input  1  write flag, accepted and ignored
- HADDR  input  32  address
- HREADY  input  1  bus-wide ready
- HMASTER  input  4  current master ID from arbiter
- HMASTLOCK  input  1  locked-sequence flag from arbiter
- HREADYOUT  output  1  slave ready
- HRESP  output  2  0 OKAY, 1 ERROR, 3 SPLIT
- HRDATA  output  32  read data
- HSPLITx  output  16  one-hot-or-multi release vector to arbiter

Behaviour:
- Reset (HRESETn low at posedge): HREADYOUT=1, HRESP=0, HRDATA=0, HSPLITx=0, pending mask=0, both FSMs idle. Reset mid-job discards the job; no HSPLITx is issued for it.
- Valid transfer: sampled at posedge when HSEL=1, HTRANS[1]=1, HREADY=1. All other cycles give OKAY, HREADYOUT=1.
- Job FSM: J_IDLE, J_RUN, J_DONE. Registers owner[3:0], job_addr[31:0], and an 8-bit counter.
  - J_IDLE + valid non-locked transfer: capture owner=HMASTER and job_addr=HADDR; counter=LATENCY-1; go to J_RUN; respond SPLIT.
  - J_RUN: decrement each cycle; at 0 go to J_DONE. HSPLITx[owner]=1 for exactly the first J_DONE cycle.
  - J_DONE + valid transfer with HMASTER==owner: OKAY, zero wait, HRDATA=job_addr during that data phase; go to J_IDLE.
  - Owner retry completes regardless of HADDR.
- Other masters while J_RUN/J_DONE, non-locked: respond SPLIT and set pending[HMASTER].
  - A transfer from owner during J_RUN also gets SPLIT, but the owner is never added to pending.
- Pending release: in the cycle after the job retires to J_IDLE, HSPLITx |= pending for one cycle, then pending clears.
  - A SPLIT recorded in the release cycle survives into the next mask; it is not lost.
- Locked transfers (HMASTLOCK=1):
  - In J_IDLE: never split. HREADYOUT=0 for LATENCY cycles, then OKAY with HRDATA=HADDR captured. No job state is left behind.
  - In J_RUN/J_DONE: respond ERROR.
- Response FSM: R_OK, R_WAIT, R_FIRST, R_SECOND.
  - SPLIT and ERROR are two-cycle: R_FIRST drives HREADYOUT=0 with HRESP=code; R_SECOND drives HREADYOUT=1 with HRESP=code; then R_OK.
  - R_WAIT serves the locked wait states.
  - No new transfer is sampled while HREADYOUT=0.
- HRDATA is 0 outside OKAY read completions.
- HSPLITx bits are only ever high for one cycle per release event.

Test Plan:
- Reset, then master 3 NONSEQ to 0x1000 (LATENCY=8) -> two-cycle SPLIT; HSPLITx=0x0008 for one cycle 8 cycles after capture; retry by master 3 -> OKAY, HRDATA=0x00001000.
- Job running for master 3; master 5 and master 9 NONSEQ -> each gets SPLIT; after master 3 retires, HSPLITx=0x0220 for one cycle, then 0.
- Master 2 locked NONSEQ to 0x40 in J_IDLE -> HREADYOUT low 8 cycles, OKAY, HRDATA=0x40, HSPLITx stays 0.
- Master 7 locked transfer while master 3 job runs -> two-cycle ERROR; job completes normally.
- Master 4 SPLIT in the exact release cycle of pending mask 0x0020 -> HSPLITx=0x0020, then on the next release 0x0010.
- HRESETn low for 1 cycle at counter=3 -> all outputs at reset values, no HSPLITx pulse afterwards; new transfer from master 1 starts a fresh job.
